// File: rtl/hs_pkg.sv
// hs_pkg: shared constants and helpers for the handshake slice chain.
//   MODE_FWD / MODE_SKID / MODE_FULL select the per-stage slice type.
//   capacity(n, mode) returns the number of words an n-stage chain can hold.
//   full_state_e is the occupancy state of a two-entry full slice.
package hs_pkg;

    localparam int MODE_FWD  = 0;
    localparam int MODE_SKID = 1;
    localparam int MODE_FULL = 2;

    typedef enum logic [1:0] {
        SL_EMPTY = 2'd0,
        SL_ONE   = 2'd1,
        SL_TWO   = 2'd2
    } full_state_e;

    function automatic int capacity(input int n, input int mode);
        return (mode == MODE_FULL) ? 2 * n : n;
    endfunction

endpackage

// File: rtl/hs_slice.sv
// hs_slice: one valid/ready pipeline stage, type chosen by MODE.
//   clk, rst          clock, async active-high reset
//   flush             synchronous discard; forces ready_f=0, valid_b=0
//   valid_f/ready_f/data_f  upstream handshake
//   valid_b/ready_b/data_b  downstream handshake
//
// Full-slice (MODE_FULL) occupancy FSM:
//   state    | meaning
//   SL_EMPTY | no word held, ready_f=1, valid_b=0
//   SL_ONE   | head word held, ready_f=1, valid_b=1
//   SL_TWO   | head + tail held, ready_f=0, valid_b=1
module hs_slice
    import hs_pkg::*;
#(
    parameter int L    = 8,
    parameter int MODE = MODE_FULL
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         valid_f,
    output logic         ready_f,
    input  logic [L-1:0] data_f,
    output logic         valid_b,
    input  logic         ready_b,
    output logic [L-1:0] data_b
);

    if (MODE == MODE_FWD) begin : g_fwd
        logic         valid_q, valid_d;
        logic [L-1:0] data_q, data_d;
        logic         stage_ready;

        always_comb begin
            stage_ready = ~flush & (ready_b | ~valid_q);
            valid_d     = valid_q;
            data_d      = data_q;
            if (flush) begin
                valid_d = 1'b0;
            end else if (stage_ready) begin
                valid_d = valid_f;
                if (valid_f) data_d = data_f;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign ready_f = stage_ready;
        assign valid_b = valid_q & ~flush;
        assign data_b  = data_q;

    end else if (MODE == MODE_SKID) begin : g_skid
        logic         skid_full_q, skid_full_d;
        logic [L-1:0] skid_data_q, skid_data_d;
        logic         ready_q, ready_d;

        always_comb begin
            skid_full_d = skid_full_q;
            skid_data_d = skid_data_q;
            if (flush) begin
                skid_full_d = 1'b0;
            end else if (!skid_full_q) begin
                // Word accepted while downstream stalls: park it in the skid.
                if (valid_f && !ready_b) begin
                    skid_full_d = 1'b1;
                    skid_data_d = data_f;
                end
            end else if (ready_b) begin
                skid_full_d = 1'b0;
            end
            ready_d = ~skid_full_d;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                skid_full_q <= 1'b0;
                skid_data_q <= '0;
                ready_q     <= 1'b1;
            end else begin
                skid_full_q <= skid_full_d;
                skid_data_q <= skid_data_d;
                ready_q     <= ready_d;
            end
        end

        // Empty skid passes upstream straight through; rst gates the path so
        // nothing leaks out while the chain is held in reset.
        assign ready_f = ready_q & ~flush;
        assign valid_b = ~rst & ~flush & (skid_full_q | valid_f);
        assign data_b  = skid_full_q ? skid_data_q : (valid_b ? data_f : '0);

    end else begin : g_full
        full_state_e  state_q, state_d;
        logic [L-1:0] head_q, head_d;
        logic [L-1:0] tail_q, tail_d;
        logic         ready_q, ready_d;
        logic         valid_q, valid_d;
        logic         push, pop;

        assign ready_f = ready_q & ~flush;
        assign valid_b = valid_q & ~flush;
        assign data_b  = head_q;
        assign push    = valid_f & ready_f;
        assign pop     = valid_b & ready_b;

        always_comb begin
            state_d = state_q;
            head_d  = head_q;
            tail_d  = tail_q;
            if (flush) begin
                state_d = SL_EMPTY;
            end else begin
                unique case (state_q)
                    SL_EMPTY: begin
                        if (push) begin
                            head_d  = data_f;
                            state_d = SL_ONE;
                        end
                    end
                    SL_ONE: begin
                        if (push && pop) begin
                            head_d = data_f;
                        end else if (push) begin
                            tail_d  = data_f;
                            state_d = SL_TWO;
                        end else if (pop) begin
                            state_d = SL_EMPTY;
                        end
                    end
                    SL_TWO: begin
                        if (pop) begin
                            head_d  = tail_q;
                            state_d = SL_ONE;
                        end
                    end
                    default: state_d = SL_EMPTY;
                endcase
            end
            ready_d = (state_d != SL_TWO);
            valid_d = (state_d != SL_EMPTY);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= SL_EMPTY;
                head_q  <= '0;
                tail_q  <= '0;
                ready_q <= 1'b1;
                valid_q <= 1'b0;
            end else begin
                state_q <= state_d;
                head_q  <= head_d;
                tail_q  <= tail_d;
                ready_q <= ready_d;
                valid_q <= valid_d;
            end
        end
    end

endmodule

// File: rtl/hs_slice_chain.sv
// hs_slice_chain: N cascaded hs_slice stages of one MODE with a word counter.
//   clk, rst          clock, async active-high reset
//   flush             synchronous discard of every held word
//   valid_f/ready_f/data_f  upstream handshake (into stage 0)
//   valid_b/ready_b/data_b  downstream handshake (out of stage N-1)
//   count             words currently held, 0..CAP
module hs_slice_chain
    import hs_pkg::*;
#(
    parameter  int L    = 8,
    parameter  int N    = 2,
    parameter  int MODE = MODE_FULL,
    localparam int CAP  = capacity(N, MODE),
    localparam int CW   = $clog2(CAP + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          valid_f,
    output logic          ready_f,
    input  logic [L-1:0]  data_f,
    output logic          valid_b,
    input  logic          ready_b,
    output logic [L-1:0]  data_b,
    output logic [CW-1:0] count
);

    logic         v_c [N+1];
    logic         r_c [N+1];
    logic [L-1:0] d_c [N+1];

    assign v_c[0]  = valid_f;
    assign d_c[0]  = data_f;
    assign r_c[N]  = ready_b;
    assign ready_f = r_c[0];
    assign valid_b = v_c[N];
    assign data_b  = d_c[N];

    for (genvar i = 0; i < N; i++) begin : g_stage
        hs_slice #(
            .L    (L),
            .MODE (MODE)
        ) u_slice (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .valid_f (v_c[i]),
            .ready_f (r_c[i]),
            .data_f  (d_c[i]),
            .valid_b (v_c[i+1]),
            .ready_b (r_c[i+1]),
            .data_b  (d_c[i+1])
        );
    end

    logic          in_xfer, out_xfer;
    logic [CW-1:0] count_q, count_d;

    // ready_f/valid_b are already forced low during flush, so no transfer
    // can be counted in a flush cycle.
    assign in_xfer  = valid_f & ready_f;
    assign out_xfer = valid_b & ready_b;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (in_xfer && !out_xfer) begin
            count_d = count_q + CW'(1);
        end else if (out_xfer && !in_xfer) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: tb/tb_hs_slice_chain.sv
module tb_hs_slice_chain;

    // Instances: 0 = MODE0 N3, 1 = MODE0 N2, 2 = MODE1 N1, 3 = MODE2 N3, 4 = MODE2 N2
    logic       clk = 1'b0;
    logic       rst;
    logic       vf [5];
    logic       rb [5];
    logic       fl [5];
    logic [7:0] df [5];
    logic       rf [5];
    logic       vb [5];
    logic [7:0] db [5];
    logic [1:0] cnt0, cnt1;
    logic       cnt2;
    logic [2:0] cnt3, cnt4;
    int         cnt [5];

    int checks   = 0;
    int failures = 0;
    int mode_of [5];
    int n_of    [5];
    int cap_of  [5];

    assign cnt[0] = int'(cnt0);
    assign cnt[1] = int'(cnt1);
    assign cnt[2] = int'(cnt2);
    assign cnt[3] = int'(cnt3);
    assign cnt[4] = int'(cnt4);

    always #5 clk = ~clk;

    hs_slice_chain #(.L(8), .N(3), .MODE(0)) u_f3 (
        .clk(clk), .rst(rst), .flush(fl[0]), .valid_f(vf[0]), .ready_f(rf[0]), .data_f(df[0]),
        .valid_b(vb[0]), .ready_b(rb[0]), .data_b(db[0]), .count(cnt0));
    hs_slice_chain #(.L(8), .N(2), .MODE(0)) u_f2 (
        .clk(clk), .rst(rst), .flush(fl[1]), .valid_f(vf[1]), .ready_f(rf[1]), .data_f(df[1]),
        .valid_b(vb[1]), .ready_b(rb[1]), .data_b(db[1]), .count(cnt1));
    hs_slice_chain #(.L(8), .N(1), .MODE(1)) u_s1 (
        .clk(clk), .rst(rst), .flush(fl[2]), .valid_f(vf[2]), .ready_f(rf[2]), .data_f(df[2]),
        .valid_b(vb[2]), .ready_b(rb[2]), .data_b(db[2]), .count(cnt2));
    hs_slice_chain #(.L(8), .N(3), .MODE(2)) u_c3 (
        .clk(clk), .rst(rst), .flush(fl[3]), .valid_f(vf[3]), .ready_f(rf[3]), .data_f(df[3]),
        .valid_b(vb[3]), .ready_b(rb[3]), .data_b(db[3]), .count(cnt3));
    hs_slice_chain #(.L(8), .N(2), .MODE(2)) u_c2 (
        .clk(clk), .rst(rst), .flush(fl[4]), .valid_f(vf[4]), .ready_f(rf[4]), .data_f(df[4]),
        .valid_b(vb[4]), .ready_b(rb[4]), .data_b(db[4]), .count(cnt4));

    task automatic to_drive_point();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int k = 0; k < 5; k++) begin
            vf[k] = 1'b0; rb[k] = 1'b0; fl[k] = 1'b0; df[k] = 8'h00;
        end
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int seen;
        do_reset();
        @(negedge clk);
        checks++;
        if (vb[3] !== 1'b0 || cnt[3] !== 0 || rf[3] !== 1'b1 || db[3] !== 8'h00) begin
            failures++;
            $display("FAIL reset_idle: got vb=%0b cnt=%0d rf=%0b db=%0h required 0 0 1 00",
                     vb[3], cnt[3], rf[3], db[3]);
        end
        to_drive_point();
        rb[3] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vf[3] = 1'b1;
            df[3] = 8'(8'h11 * (i + 1));
            to_drive_point();
        end
        vf[3] = 1'b0;
        @(negedge clk);
        checks++;
        if (cnt[3] !== 3) begin
            failures++;
            $display("FAIL reset_prefill_count: got %0d required 3", cnt[3]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (vb[3] !== 1'b0 || cnt[3] !== 0 || rf[3] !== 1'b1 || db[3] !== 8'h00) begin
            failures++;
            $display("FAIL reset_midflight: got vb=%0b cnt=%0d rf=%0b db=%0h required 0 0 1 00",
                     vb[3], cnt[3], rf[3], db[3]);
        end
        to_drive_point();
        rst = 1'b0;
        rb[3] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (vb[3] !== 1'b0) begin
                failures++;
                $display("FAIL reset_no_stale: got valid_b=%0b required 0 (cycle %0d)", vb[3], c);
            end
            to_drive_point();
        end
        vf[3] = 1'b1;
        df[3] = 8'h77;
        to_drive_point();
        vf[3] = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (vb[3] === 1'b1) begin
                seen = 1;
                checks++;
                if (db[3] !== 8'h77) begin
                    failures++;
                    $display("FAIL reset_first_word: got %0h required 77", db[3]);
                end
            end
            to_drive_point();
        end
        checks++;
        if (seen == 0) begin
            failures++;
            $display("FAIL reset_first_word_timeout: got no output required 77");
        end
    endtask

    task automatic test_stream();
        int sent, got, acc_cyc, out_cyc;
        do_reset();
        rb[0] = 1'b1;
        sent = 0; got = 0; acc_cyc = -1; out_cyc = -1;
        for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
            vf[0] = (sent < 16);
            df[0] = 8'(sent + 1);
            @(negedge clk);
            if (vb[0] === 1'b1) begin
                checks++;
                if (db[0] !== 8'(got + 1)) begin
                    failures++;
                    $display("FAIL stream_data: got %0h required %0h", db[0], 8'(got + 1));
                end
                if (out_cyc < 0) out_cyc = cyc;
                checks++;
                if (cyc != out_cyc + got) begin
                    failures++;
                    $display("FAIL stream_rate: word %0d at cycle %0d required cycle %0d",
                             got, cyc, out_cyc + got);
                end
                got++;
            end
            if (vf[0] && rf[0] === 1'b1) begin
                if (acc_cyc < 0) acc_cyc = cyc;
                sent++;
            end
            to_drive_point();
        end
        vf[0] = 1'b0;
        checks++;
        if (got != 16) begin
            failures++;
            $display("FAIL stream_count: got %0d words required 16", got);
        end
        checks++;
        if (out_cyc - acc_cyc != 3) begin
            failures++;
            $display("FAIL stream_latency: got %0d cycles required 3", out_cyc - acc_cyc);
        end
    endtask

    task automatic test_backpressure();
        int acc, got;
        do_reset();
        rb[4] = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            vf[4] = 1'b1;
            df[4] = 8'(8'hA0 + acc);
            @(negedge clk);
            if (rf[4] === 1'b1) acc++;
            to_drive_point();
        end
        vf[4] = 1'b0;
        @(negedge clk);
        checks++;
        if (acc != 4 || rf[4] !== 1'b0 || cnt[4] !== 4) begin
            failures++;
            $display("FAIL bp_full: got acc=%0d rf=%0b cnt=%0d required 4 0 4", acc, rf[4], cnt[4]);
        end
        to_drive_point();
        rb[4] = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (vb[4] === 1'b1) begin
                checks++;
                if (db[4] !== 8'(8'hA0 + got)) begin
                    failures++;
                    $display("FAIL bp_order: got %0h required %0h", db[4], 8'(8'hA0 + got));
                end
                got++;
            end
            to_drive_point();
        end
        @(negedge clk);
        checks++;
        if (got != 4 || cnt[4] !== 0) begin
            failures++;
            $display("FAIL bp_drain: got words=%0d cnt=%0d required 4 0", got, cnt[4]);
        end
        to_drive_point();
    endtask

    task automatic test_skid();
        do_reset();
        rb[2] = 1'b0;
        vf[2] = 1'b1;
        df[2] = 8'h55;
        @(negedge clk);
        checks++;
        if (rf[2] !== 1'b1) begin
            failures++;
            $display("FAIL skid_accept: got ready_f=%0b required 1", rf[2]);
        end
        to_drive_point();
        vf[2] = 1'b0;
        df[2] = 8'h00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (rf[2] !== 1'b0 || vb[2] !== 1'b1 || db[2] !== 8'h55) begin
                failures++;
                $display("FAIL skid_hold: got rf=%0b vb=%0b db=%0h required 0 1 55", rf[2], vb[2], db[2]);
            end
            to_drive_point();
        end
        rb[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (vb[2] !== 1'b1 || db[2] !== 8'h55) begin
            failures++;
            $display("FAIL skid_release: got vb=%0b db=%0h required 1 55", vb[2], db[2]);
        end
        to_drive_point();
        @(negedge clk);
        checks++;
        if (vb[2] !== 1'b0 || rf[2] !== 1'b1 || cnt[2] !== 0) begin
            failures++;
            $display("FAIL skid_empty: got vb=%0b rf=%0b cnt=%0d required 0 1 0", vb[2], rf[2], cnt[2]);
        end
        to_drive_point();
        vf[2] = 1'b1;
        df[2] = 8'h3C;
        @(negedge clk);
        checks++;
        if (vb[2] !== 1'b1 || db[2] !== 8'h3C || rf[2] !== 1'b1) begin
            failures++;
            $display("FAIL skid_passthrough: got vb=%0b db=%0h rf=%0b required 1 3c 1", vb[2], db[2], rf[2]);
        end
        to_drive_point();
        vf[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (cnt[2] !== 0) begin
            failures++;
            $display("FAIL skid_passthrough_count: got %0d required 0", cnt[2]);
        end
        to_drive_point();
    endtask

    task automatic fill_chain(input int k, input int words, input logic [7:0] base);
        int acc;
        acc = 0;
        rb[k] = 1'b0;
        for (int cyc = 0; cyc < 12 && acc < words; cyc++) begin
            vf[k] = 1'b1;
            df[k] = 8'(base + acc);
            @(negedge clk);
            if (rf[k] === 1'b1) acc++;
            to_drive_point();
        end
        vf[k] = 1'b0;
    endtask

    task automatic test_flush();
        int seen;
        do_reset();
        fill_chain(4, 4, 8'h10);
        @(negedge clk);
        checks++;
        if (cnt[4] !== 4) begin
            failures++;
            $display("FAIL flush_prefill: got count=%0d required 4", cnt[4]);
        end
        to_drive_point();
        fl[4] = 1'b1; vf[4] = 1'b1; df[4] = 8'hEE; rb[4] = 1'b1;
        @(negedge clk);
        checks++;
        if (rf[4] !== 1'b0 || vb[4] !== 1'b0) begin
            failures++;
            $display("FAIL flush_gate: got rf=%0b vb=%0b required 0 0", rf[4], vb[4]);
        end
        to_drive_point();
        fl[4] = 1'b0; vf[4] = 1'b0;
        @(negedge clk);
        checks++;
        if (cnt[4] !== 0 || vb[4] !== 1'b0) begin
            failures++;
            $display("FAIL flush_empty: got cnt=%0d vb=%0b required 0 0", cnt[4], vb[4]);
        end
        to_drive_point();
        vf[4] = 1'b1; df[4] = 8'h99;
        to_drive_point();
        vf[4] = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (vb[4] === 1'b1) begin
                seen = 1;
                checks++;
                if (db[4] !== 8'h99) begin
                    failures++;
                    $display("FAIL flush_first_word: got %0h required 99", db[4]);
                end
            end
            to_drive_point();
        end
        checks++;
        if (seen == 0) begin
            failures++;
            $display("FAIL flush_first_word_timeout: got no output required 99");
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        fill_chain(1, 2, 8'h01);
        @(negedge clk);
        checks++;
        if (cnt[1] !== 2) begin
            failures++;
            $display("FAIL simul_fwd_fill: got count=%0d required 2", cnt[1]);
        end
        to_drive_point();
        vf[1] = 1'b1; df[1] = 8'h03; rb[1] = 1'b1;
        @(negedge clk);
        checks++;
        if (rf[1] !== 1'b1 || vb[1] !== 1'b1 || db[1] !== 8'h01) begin
            failures++;
            $display("FAIL simul_fwd_both: got rf=%0b vb=%0b db=%0h required 1 1 01", rf[1], vb[1], db[1]);
        end
        to_drive_point();
        vf[1] = 1'b0; rb[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (cnt[1] !== 2 || db[1] !== 8'h02) begin
            failures++;
            $display("FAIL simul_fwd_after: got cnt=%0d db=%0h required 2 02", cnt[1], db[1]);
        end
        to_drive_point();

        do_reset();
        fill_chain(4, 4, 8'h40);
        vf[4] = 1'b1; df[4] = 8'h05; rb[4] = 1'b1;
        @(negedge clk);
        checks++;
        if (rf[4] !== 1'b0 || vb[4] !== 1'b1 || db[4] !== 8'h40) begin
            failures++;
            $display("FAIL simul_full_block: got rf=%0b vb=%0b db=%0h required 0 1 40", rf[4], vb[4], db[4]);
        end
        to_drive_point();
        vf[4] = 1'b0; rb[4] = 1'b0;
        @(negedge clk);
        checks++;
        if (cnt[4] !== 3) begin
            failures++;
            $display("FAIL simul_full_after: got count=%0d required 3", cnt[4]);
        end
        to_drive_point();
    endtask

    // Reference: a chain is an ordered store of at most CAP words.
    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] exp_d;
        logic       in_x, out_x, prev_hold, exp_rf, exp_vb;
        logic [7:0] prev_data;
        for (int k = 0; k < 5; k++) begin
            do_reset();
            q.delete();
            prev_hold = 1'b0;
            prev_data = 8'h00;
            for (int cyc = 0; cyc < 400; cyc++) begin
                vf[k] = ($urandom_range(0, 3) != 0);
                df[k] = 8'($urandom_range(0, 255));
                rb[k] = ($urandom_range(0, 3) < ((cyc / 50) % 3 + 1));
                fl[k] = ($urandom_range(0, 39) == 0);
                @(negedge clk);
                checks++;
                if (cnt[k] !== q.size()) begin
                    failures++;
                    $display("FAIL rand_count[%0d]: got %0d required %0d (cycle %0d)", k, cnt[k], q.size(), cyc);
                end
                if (prev_hold && !fl[k]) begin
                    checks++;
                    if (vb[k] !== 1'b1 || db[k] !== prev_data) begin
                        failures++;
                        $display("FAIL rand_stable[%0d]: got vb=%0b db=%0h required 1 %0h", k, vb[k], db[k], prev_data);
                    end
                end
                if (fl[k]) begin
                    checks++;
                    if (rf[k] !== 1'b0 || vb[k] !== 1'b0) begin
                        failures++;
                        $display("FAIL rand_flush[%0d]: got rf=%0b vb=%0b required 0 0", k, rf[k], vb[k]);
                    end
                    q.delete();
                    prev_hold = 1'b0;
                end else begin
                    if (mode_of[k] == 0) begin
                        exp_rf = rb[k] || (q.size() < n_of[k]);
                        checks++;
                        if (rf[k] !== exp_rf) begin
                            failures++;
                            $display("FAIL rand_fwd_ready[%0d]: got %0b required %0b", k, rf[k], exp_rf);
                        end
                    end else if (mode_of[k] == 1) begin
                        exp_rf = (q.size() == 0);
                        exp_vb = (q.size() == 1) || vf[k];
                        checks++;
                        if (rf[k] !== exp_rf || vb[k] !== exp_vb) begin
                            failures++;
                            $display("FAIL rand_skid[%0d]: got rf=%0b vb=%0b required %0b %0b", k, rf[k], vb[k], exp_rf, exp_vb);
                        end
                    end else if (q.size() == cap_of[k]) begin
                        checks++;
                        if (rf[k] !== 1'b0) begin
                            failures++;
                            $display("FAIL rand_full_ready[%0d]: got %0b required 0", k, rf[k]);
                        end
                    end
                    if (mode_of[k] != 1 && q.size() == 0) begin
                        checks++;
                        if (vb[k] !== 1'b0 || rf[k] !== 1'b1) begin
                            failures++;
                            $display("FAIL rand_empty[%0d]: got vb=%0b rf=%0b required 0 1", k, vb[k], rf[k]);
                        end
                    end
                    in_x  = vf[k] && (rf[k] === 1'b1);
                    out_x = (vb[k] === 1'b1) && rb[k];
                    if (out_x) begin
                        exp_d = (q.size() > 0) ? q[0] : df[k];
                        checks++;
                        if (db[k] !== exp_d) begin
                            failures++;
                            $display("FAIL rand_order[%0d]: got %0h required %0h (cycle %0d)", k, db[k], exp_d, cyc);
                        end
                    end
                    if (in_x) q.push_back(df[k]);
                    if (out_x && q.size() > 0) void'(q.pop_front());
                    prev_hold = (vb[k] === 1'b1) && !rb[k];
                    prev_data = db[k];
                end
                to_drive_point();
            end
            vf[k] = 1'b0; rb[k] = 1'b0; fl[k] = 1'b0;
        end
    endtask

    initial begin
        mode_of = '{0, 0, 1, 2, 2};
        n_of    = '{3, 2, 1, 3, 2};
        cap_of  = '{3, 2, 1, 6, 4};
        rst = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_skid();
        test_flush();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
